cnt_obi_arbiter: RTL and testbench

CNT_OBI_ARBITER -- requirements
Module: cnt_obi_arbiter

---
 rtl/cnt_obi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cnt_obi_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_obi_arbiter.sv
// Round-robin OBI arbiter: NumReq upstream requesters share one downstream OBI port.
// Requests and responses are forwarded combinationally; an ID FIFO records which
// requester owns each outstanding transaction so responses can be steered back.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   up_req_i/up_we_i              per-requester request / write enable
//   up_be_i/up_addr_i/up_wdata_i  per-requester request payload, requester i in slice i
//   up_gnt_o/up_rvalid_o          per-requester grant / read-valid (one-hot or zero)
//   up_rdata_o                    read data shared by all requesters
//   dn_req_o..dn_wdata_o          downstream request
//   dn_gnt_i/dn_rvalid_i/dn_rdata_i  downstream response
//   err_o                         sticky: downstream rvalid arrived with nothing outstanding
module cnt_obi_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned MaxOut = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          up_req_i,
  input  logic [NumReq-1:0]          up_we_i,
  input  logic [NumReq*(DW/8)-1:0]   up_be_i,
  input  logic [NumReq*AW-1:0]       up_addr_i,
  input  logic [NumReq*DW-1:0]       up_wdata_i,
  output logic [NumReq-1:0]          up_gnt_o,
  output logic [NumReq-1:0]          up_rvalid_o,
  output logic [DW-1:0]              up_rdata_o,
  output logic                       dn_req_o,
  output logic                       dn_we_o,
  output logic [DW/8-1:0]            dn_be_o,
  output logic [AW-1:0]              dn_addr_o,
  output logic [DW-1:0]              dn_wdata_o,
  input  logic                       dn_gnt_i,
  input  logic                       dn_rvalid_i,
  input  logic [DW-1:0]              dn_rdata_i,
  output logic                       err_o
);

  localparam int unsigned BEW = DW / 8;
  localparam int unsigned IW  = $clog2(NumReq);
  localparam int unsigned PW  = (MaxOut > 1) ? $clog2(MaxOut) : 1;
  localparam int unsigned CW  = $clog2(MaxOut + 1);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0] fifo_q [MaxOut];

  logic          arb_valid;
  logic [IW-1:0] arb_id;
  logic          req_valid;
  logic [IW-1:0] winner;
  logic          pop, push, block;
  logic [IW-1:0] head;

  // Round-robin search: iterate from lowest priority to highest so the last hit wins.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % int'(NumReq);
      if (up_req_i[idx]) begin
        arb_valid = 1'b1;
        arb_id    = IW'(idx);
      end
    end
  end

  // A stalled request keeps its requester; if that requester withdraws, nothing is
  // presented this cycle and the lock drops so arbitration resumes next cycle.
  always_comb begin
    if (lock_q) begin
      winner    = lock_id_q;
      req_valid = up_req_i[lock_id_q];
    end else begin
      winner    = arb_id;
      req_valid = arb_valid;
    end
  end

  assign head     = fifo_q[rd_q];
  assign pop      = dn_rvalid_i & (cnt_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO only blocks without one.
  assign block    = (cnt_q == CW'(MaxOut)) & ~pop;
  assign dn_req_o = rst_ni & req_valid & ~block;
  assign push     = dn_req_o & dn_gnt_i;

  assign up_rdata_o = dn_rdata_i;
  assign err_o      = err_q;

  always_comb begin
    up_gnt_o         = '0;
    up_gnt_o[winner] = push;
    up_rvalid_o      = '0;
    up_rvalid_o[head] = pop;
  end

  always_comb begin
    dn_we_o    = 1'b0;
    dn_be_o    = '0;
    dn_addr_o  = '0;
    dn_wdata_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (dn_req_o && (winner == IW'(i))) begin
        dn_we_o    = up_we_i[i];
        dn_be_o    = up_be_i[i*BEW +: BEW];
        dn_addr_o  = up_addr_i[i*AW +: AW];
        dn_wdata_o = up_wdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = dn_req_o & ~dn_gnt_i;
    lock_id_d = winner;
    err_d     = err_q | (dn_rvalid_i & (cnt_q == '0));
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (push) begin
      ptr_d = (winner == IW'(NumReq - 1)) ? '0 : winner + IW'(1);
      wr_d  = (wr_q == PW'(MaxOut - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PW'(MaxOut - 1)) ? '0 : rd_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_cnt_obi_arbiter.sv
module tb_cnt_obi_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [3:0]   up_req_i, up_we_i;
  logic [15:0]  up_be_i;
  logic [127:0] up_addr_i, up_wdata_i;
  logic [3:0]   up_gnt_o, up_rvalid_o;
  logic [31:0]  up_rdata_o;
  logic         dn_req_o, dn_we_o;
  logic [3:0]   dn_be_o;
  logic [31:0]  dn_addr_o, dn_wdata_o;
  logic         dn_gnt_i, dn_rvalid_i;
  logic [31:0]  dn_rdata_i;
  logic         err_o;

  int total = 0;
  int bad   = 0;
  int sb[$];

  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic       dnreq;
    int         win;
  } step_t;

  cnt_obi_arbiter #(.NumReq(4), .AW(32), .DW(32), .MaxOut(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .up_req_i    (up_req_i),
    .up_we_i     (up_we_i),
    .up_be_i     (up_be_i),
    .up_addr_i   (up_addr_i),
    .up_wdata_i  (up_wdata_i),
    .up_gnt_o    (up_gnt_o),
    .up_rvalid_o (up_rvalid_o),
    .up_rdata_o  (up_rdata_o),
    .dn_req_o    (dn_req_o),
    .dn_we_o     (dn_we_o),
    .dn_be_o     (dn_be_o),
    .dn_addr_o   (dn_addr_o),
    .dn_wdata_o  (dn_wdata_o),
    .dn_gnt_i    (dn_gnt_i),
    .dn_rvalid_i (dn_rvalid_i),
    .dn_rdata_i  (dn_rdata_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [3:0] req, input logic gnt, input logic rv);
    @(negedge clk_i);
    up_req_i    = req;
    dn_gnt_i    = gnt;
    dn_rvalid_i = rv;
    dn_rdata_i  = $urandom;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    up_req_i = '0; dn_gnt_i = 1'b0; dn_rvalid_i = 1'b0;
    sb.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Runs a stimulus table; expected handshakes feed the scoreboard, responses drain it.
  task automatic run_steps(input string name, input step_t st[$]);
    logic [3:0]  exp_gnt, exp_rv, exp_be;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    foreach (st[k]) begin
      drive(st[k].req, st[k].gnt, st[k].rv);
      exp_gnt   = (st[k].dnreq && st[k].gnt) ? 4'(1 << st[k].win) : 4'b0;
      exp_addr  = st[k].dnreq ? 32'hA000_0000 + 32'(st[k].win) : 32'h0;
      exp_wdata = st[k].dnreq ? 32'hD000_0000 + 32'(st[k].win) : 32'h0;
      exp_be    = st[k].dnreq ? 4'(st[k].win + 1) : 4'h0;
      exp_we    = st[k].dnreq ? (st[k].win % 2 == 1) : 1'b0;
      exp_rv    = '0;
      if (st[k].rv && sb.size() > 0) exp_rv = 4'(1 << sb.pop_front());
      total++;
      if (dn_req_o !== st[k].dnreq) begin
        bad++;
        $display("FAIL %s_dn_req step %0d: got %b want %b", name, k, dn_req_o, st[k].dnreq);
      end
      total++;
      if (up_gnt_o !== exp_gnt) begin
        bad++;
        $display("FAIL %s_gnt step %0d: got %b want %b", name, k, up_gnt_o, exp_gnt);
      end
      total++;
      if ({dn_addr_o, dn_wdata_o, dn_be_o, dn_we_o} !== {exp_addr, exp_wdata, exp_be, exp_we})
      begin
        bad++;
        $display("FAIL %s_payload step %0d: got %h/%h/%h/%b want %h/%h/%h/%b", name, k,
                 dn_addr_o, dn_wdata_o, dn_be_o, dn_we_o, exp_addr, exp_wdata, exp_be, exp_we);
      end
      total++;
      if (up_rvalid_o !== exp_rv) begin
        bad++;
        $display("FAIL %s_rvalid step %0d: got %b want %b", name, k, up_rvalid_o, exp_rv);
      end
      total++;
      if (up_rdata_o !== dn_rdata_i) begin
        bad++;
        $display("FAIL %s_rdata step %0d: got %h want %h", name, k, up_rdata_o, dn_rdata_i);
      end
      if (st[k].dnreq && st[k].gnt) sb.push_back(st[k].win);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(4'hF, 1'b1, 1'b1);
    total++;
    if ({dn_req_o, up_gnt_o, up_rvalid_o, err_o, dn_addr_o} !== 42'h0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b gnt=%b rv=%b err=%b addr=%h want all 0",
               dn_req_o, up_gnt_o, up_rvalid_o, err_o, dn_addr_o);
    end
    drive(4'h0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    drive(4'h0, 1'b0, 1'b0);
    total++;
    if ({dn_req_o, up_gnt_o, up_rvalid_o, err_o} !== 10'h0) begin
      bad++;
      $display("FAIL reset_release: got req=%b gnt=%b rv=%b err=%b want all 0",
               dn_req_o, up_gnt_o, up_rvalid_o, err_o);
    end
  endtask

  task automatic test_round_robin();
    step_t st[$];
    st = '{'{4'hF, 1'b1, 1'b0, 1'b1, 0},
           '{4'hF, 1'b1, 1'b1, 1'b1, 1},
           '{4'hF, 1'b1, 1'b1, 1'b1, 2},
           '{4'hF, 1'b1, 1'b1, 1'b1, 3},
           '{4'hF, 1'b1, 1'b1, 1'b1, 0},
           '{4'h0, 1'b0, 1'b1, 1'b0, -1}};
    run_steps("rr", st);
  endtask

  task automatic test_lock();
    step_t st[$];
    do_reset();
    st = '{'{4'b0100, 1'b0, 1'b0, 1'b1, 2},
           '{4'b0101, 1'b0, 1'b0, 1'b1, 2},
           '{4'b0101, 1'b0, 1'b0, 1'b1, 2},
           '{4'b0101, 1'b1, 1'b0, 1'b1, 2},
           '{4'b0101, 1'b1, 1'b0, 1'b1, 0},
           '{4'b0000, 1'b0, 1'b1, 1'b0, -1},
           '{4'b0000, 1'b0, 1'b1, 1'b0, -1}};
    run_steps("lock", st);
  endtask

  task automatic test_full();
    step_t st[$];
    st = '{'{4'b0110, 1'b1, 1'b0, 1'b1, 1},
           '{4'b0110, 1'b1, 1'b0, 1'b1, 2},
           '{4'b0110, 1'b1, 1'b0, 1'b0, -1},
           '{4'b0110, 1'b1, 1'b1, 1'b1, 1},
           '{4'b0110, 1'b1, 1'b0, 1'b0, -1},
           '{4'b0000, 1'b0, 1'b1, 1'b0, -1},
           '{4'b0000, 1'b0, 1'b1, 1'b0, -1},
           '{4'b0100, 1'b0, 1'b0, 1'b1, 2},
           '{4'b0000, 1'b0, 1'b0, 1'b0, -1}};
    run_steps("full", st);
  endtask

  task automatic test_err();
    drive(4'h0, 1'b0, 1'b1);
    total++;
    if (up_rvalid_o !== 4'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_same_cycle: got rv=%b err=%b want rv=0000 err=0", up_rvalid_o, err_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 1'b0, 1'b0);
      total++;
      if (err_o !== 1'b1) begin
        bad++;
        $display("FAIL err_sticky cycle %0d: got %b want 1", i, err_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'h0, 1'b0, 1'b0);
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_clears_err: got %b want 0", err_o);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b0100, 1'b1, 1'b0);
      total++;
      if (up_gnt_o !== 4'b0100) begin
        bad++;
        $display("FAIL rstmid_pre_gnt %0d: got %b want 0100", i, up_gnt_o);
      end
    end
    drive(4'b1010, 1'b1, 1'b1);
    rst_ni = 1'b0;
    #1;
    total++;
    if ({dn_req_o, up_gnt_o, up_rvalid_o} !== 9'h0) begin
      bad++;
      $display("FAIL rstmid_async: got req=%b gnt=%b rv=%b want all 0",
               dn_req_o, up_gnt_o, up_rvalid_o);
    end
    sb.delete();
    drive(4'h0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    drive(4'h0, 1'b0, 1'b1);
    total++;
    if (up_rvalid_o !== 4'b0) begin
      bad++;
      $display("FAIL rstmid_stale_rv: got %b want 0000", up_rvalid_o);
    end
    drive(4'b1010, 1'b1, 1'b0);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_err: got %b want 1", err_o);
    end
    total++;
    if (up_gnt_o !== 4'b0010 || dn_addr_o !== 32'hA000_0001) begin
      bad++;
      $display("FAIL rstmid_first_gnt: got gnt=%b addr=%h want 0010 a0000001",
               up_gnt_o, dn_addr_o);
    end
    do_reset();
  endtask

  initial begin
    rst_ni = 1'b0;
    up_req_i = '0; dn_gnt_i = 1'b0; dn_rvalid_i = 1'b0; dn_rdata_i = '0;
    up_we_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      up_addr_i[i*32 +: 32]  = 32'hA000_0000 + 32'(i);
      up_wdata_i[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      up_be_i[i*4 +: 4]      = 4'(i + 1);
    end
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
